// File: rtl/tpm_bus_arbiter.sv
// Arbitrates TPM SPI byte traffic and an internal requester onto one backend bus.
// Build option: define TPM_ARB_TIMEOUT_EN to abandon backend waits after TIMEOUT_CYCLES.
module tpm_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // SPI peripheral side
  input  logic [7:0]  spi_data_o,
  input  logic [15:0] spi_addr_o,
  input  logic        spi_data_wr,
  output logic        spi_wr_done,
  input  logic        spi_data_req,
  output logic [7:0]  spi_data_i,
  output logic        spi_data_rd,
  // Internal requester
  input  logic        int_req,
  input  logic        int_we,
  input  logic [15:0] int_addr,
  input  logic [7:0]  int_wdata,
  output logic [7:0]  int_rdata,
  output logic        int_ack,
  // Backend bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {StIdle, StBus, StSpiHold} state_e;

  state_e      state_q, state_d;
  logic        last_int_q, last_int_d;  // most recent grant went to the internal requester
  logic        own_int_q, own_int_d;    // current backend owner is the internal requester
  logic        spi_wr_q, spi_wr_d;      // current SPI byte is a write
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        wr_done_q, wr_done_d;
  logic        rd_vld_q, rd_vld_d;
  logic [7:0]  spi_rdata_q, spi_rdata_d;
  logic        int_ack_q, int_ack_d;
  logic [7:0]  int_rdata_q, int_rdata_d;

  logic        spi_wr_pend;
  logic        spi_rd_pend;
  logic        spi_pend;
  logic        int_pend;
  logic        grant_spi;
  logic        grant_int;
  logic        bus_done;
  logic [7:0]  done_rdata;

  assign spi_wr_pend = spi_data_wr & ~wr_done_q;
  assign spi_rd_pend = spi_data_req & ~rd_vld_q;
  assign spi_pend    = spi_wr_pend | spi_rd_pend;
  // The ack cycle masks int_req so a requester that drops on int_ack is not granted twice.
  assign int_pend    = int_req & ~int_ack_q;
  assign grant_spi   = spi_pend & (~int_pend | last_int_q);
  assign grant_int   = int_pend & ~grant_spi;

`ifdef TPM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StBus && !bus_ack) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_done   = bus_ack | timeout;
  assign done_rdata = bus_ack ? bus_rdata : 8'hFF;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus_done       = bus_ack;
  assign done_rdata     = bus_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    last_int_d  = last_int_q;
    own_int_d   = own_int_q;
    spi_wr_d    = spi_wr_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wr_done_d   = wr_done_q;
    rd_vld_d    = rd_vld_q;
    spi_rdata_d = spi_rdata_q;
    int_ack_d   = 1'b0;
    int_rdata_d = int_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_spi) begin
          own_int_d   = 1'b0;
          last_int_d  = 1'b0;
          spi_wr_d    = spi_wr_pend;
          bus_req_d   = 1'b1;
          bus_we_d    = spi_wr_pend;
          bus_addr_d  = spi_addr_o;
          bus_wdata_d = spi_wr_pend ? spi_data_o : 8'h00;
          state_d     = StBus;
        end else if (grant_int) begin
          own_int_d   = 1'b1;
          last_int_d  = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = int_we;
          bus_addr_d  = int_addr;
          bus_wdata_d = int_wdata;
          state_d     = StBus;
        end
      end

      StBus: begin
        if (bus_done) begin
          bus_req_d = 1'b0;
          if (own_int_q) begin
            int_ack_d = 1'b1;
            if (!bus_we_q) begin
              int_rdata_d = done_rdata;
            end
            state_d = StIdle;
          end else begin
            if (spi_wr_q) begin
              wr_done_d = 1'b1;
            end else begin
              rd_vld_d    = 1'b1;
              spi_rdata_d = done_rdata;
            end
            state_d = StSpiHold;
          end
        end
      end

      StSpiHold: begin
        if (spi_wr_q ? !spi_data_wr : !spi_data_req) begin
          wr_done_d = 1'b0;
          rd_vld_d  = 1'b0;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_int_q  <= 1'b1;
      own_int_q   <= 1'b0;
      spi_wr_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 8'h00;
      wr_done_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      spi_rdata_q <= 8'h00;
      int_ack_q   <= 1'b0;
      int_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      last_int_q  <= last_int_d;
      own_int_q   <= own_int_d;
      spi_wr_q    <= spi_wr_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wr_done_q   <= wr_done_d;
      rd_vld_q    <= rd_vld_d;
      spi_rdata_q <= spi_rdata_d;
      int_ack_q   <= int_ack_d;
      int_rdata_q <= int_rdata_d;
    end
  end

  assign spi_wr_done = wr_done_q;
  assign spi_data_rd = rd_vld_q;
  assign spi_data_i  = spi_rdata_q;
  assign int_ack     = int_ack_q;
  assign int_rdata   = int_rdata_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;

endmodule
